inst_queue_mw: RTL

INST_QUEUE_MW -- requirements
Module: inst_queue_mw

---
 rtl/inst_queue_mw.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/inst_queue_mw.sv
// inst_queue_mw: dual-lane circular instruction queue between fetch and dispatch.
// Up to two entries are compacted in on the tail and up to two leave from the head
// on the same edge. Dispatch lanes are registered.
// Optional macro IQ_BYPASS_EN: this cycle's incoming entries may be dispatched in
// their write cycle when the stored entries do not use up the dispatch credit.
module inst_queue_mw #(
    parameter int DEPTH        = 16,
    parameter int FULL_WARNING = 2,
    parameter int INS_W        = 32,
    parameter int ADDR_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rdy,
    input  logic                    flush,
    input  logic [1:0]              enq_valid,
    input  logic [2*INS_W-1:0]      enq_inst,
    input  logic [2*ADDR_W-1:0]     enq_pc,
    input  logic [2*ADDR_W-1:0]     enq_rb_pc,
    input  logic [1:0]              enq_pred,
    input  logic [1:0]              dsp_credit,
    output logic                    full_to_if,
    output logic [1:0]              out_valid,
    output logic [2*INS_W-1:0]      out_inst,
    output logic [2*ADDR_W-1:0]     out_pc,
    output logic [2*ADDR_W-1:0]     out_rb_pc,
    output logic [1:0]              out_pred,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = INS_W + 2*ADDR_W + 1;
    localparam logic [PTR_W+1:0] DEPTH_X  = (PTR_W+2)'(DEPTH);
    localparam logic [PTR_W:0]   WARN_LVL = (PTR_W+1)'(DEPTH - FULL_WARNING);

    // Entry layout: {pred, rb_pc, pc, inst}
    typedef logic [ENT_W-1:0] entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head, tail, head_p1, tail_p1;
    logic [PTR_W:0]     occ;
    logic [PTR_W+1:0]   occ_x, free_slots;
    logic [1:0]         enq_cnt, credit, deq_cnt, deq_st, deq_in, enq_rem, wr_cnt;
    logic               drop;
    entry_t             in_lane [2];
    entry_t             in_cmp  [2];
    entry_t             wr_ent  [2];
    entry_t             dsp_ent [2];
    entry_t             dsp_ent_p1 [2];
    logic [1:0]         vld_p1;

    function automatic logic [PTR_W+1:0] ext_cnt(input logic [1:0] c);
        return (PTR_W+2)'(c);
    endfunction

    // Smaller of a wide count and a lane count; result always fits two bits.
    function automatic logic [1:0] min_cnt(input logic [PTR_W+1:0] a, input logic [1:0] b);
        return (a < ext_cnt(b)) ? a[1:0] : b;
    endfunction

    assign head_p1 = head + PTR_W'(1);
    assign tail_p1 = tail + PTR_W'(1);
    assign occ_x   = {1'b0, occ};

    // Dequeue/enqueue counts: stored entries leave first, incoming fill the free slots.
    always_comb begin
        enq_cnt = {1'b0, enq_valid[0]} + {1'b0, enq_valid[1]};
        credit  = (dsp_credit == 2'd3) ? 2'd2 : dsp_credit;
`ifdef IQ_BYPASS_EN
        deq_cnt = min_cnt(occ_x + ext_cnt(enq_cnt), credit);
        deq_st  = min_cnt(occ_x, deq_cnt);
`else
        deq_cnt = min_cnt(occ_x, credit);
        deq_st  = deq_cnt;
`endif
        deq_in     = deq_cnt - deq_st;
        enq_rem    = enq_cnt - deq_in;
        free_slots = DEPTH_X - occ_x + ext_cnt(deq_st);
        wr_cnt     = min_cnt(free_slots, enq_rem);
        drop       = (enq_rem != wr_cnt);
    end

    // Lane packing, compaction and selection of the written and dispatched entries.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_lane[i] = {enq_pred[i], enq_rb_pc[i*ADDR_W +: ADDR_W],
                          enq_pc[i*ADDR_W +: ADDR_W], enq_inst[i*INS_W +: INS_W]};
        end
        in_cmp[0]  = enq_valid[0] ? in_lane[0] : in_lane[1];
        in_cmp[1]  = in_lane[1];
        // Incoming entries already dispatched are skipped; the rest are written.
        wr_ent[0]  = (deq_in == 2'd0) ? in_cmp[0] : in_cmp[1];
        wr_ent[1]  = in_cmp[1];
        dsp_ent[0] = mem[head];
        dsp_ent[1] = mem[head_p1];
`ifdef IQ_BYPASS_EN
        if (deq_st == 2'd0) begin
            dsp_ent[0] = in_cmp[0];
            dsp_ent[1] = in_cmp[1];
        end else if (deq_st == 2'd1) begin
            dsp_ent[1] = in_cmp[0];
        end
`endif
    end

    // Control state: pointers, occupancy, dispatch valid and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            occ          <= '0;
            vld_p1       <= 2'b00;
            overflow_err <= 1'b0;
        end else if (flush) begin
            head   <= '0;
            tail   <= '0;
            occ    <= '0;
            vld_p1 <= 2'b00;
        end else if (rdy) begin
            head   <= head + PTR_W'(deq_st);
            tail   <= tail + PTR_W'(wr_cnt);
            occ    <= occ + (PTR_W+1)'(wr_cnt) - (PTR_W+1)'(deq_st);
            vld_p1 <= (deq_cnt == 2'd0) ? 2'b00 : (deq_cnt == 2'd1) ? 2'b01 : 2'b11;
            if (drop) begin
                overflow_err <= 1'b1;
            end
        end else begin
            vld_p1 <= 2'b00;
        end
    end

    // Data path: storage writes and dispatch data registers carry no reset.
    always_ff @(posedge clk) begin
        if (rdy && !flush) begin
            if (wr_cnt != 2'd0) begin
                mem[tail] <= wr_ent[0];
            end
            if (wr_cnt == 2'd2) begin
                mem[tail_p1] <= wr_ent[1];
            end
            dsp_ent_p1[0] <= dsp_ent[0];
            dsp_ent_p1[1] <= dsp_ent[1];
        end
    end

    // ---- stage p1: registered dispatch lanes ----
    assign out_valid    = vld_p1;
    assign out_inst     = {dsp_ent_p1[1][INS_W-1:0], dsp_ent_p1[0][INS_W-1:0]};
    assign out_pc       = {dsp_ent_p1[1][INS_W +: ADDR_W], dsp_ent_p1[0][INS_W +: ADDR_W]};
    assign out_rb_pc    = {dsp_ent_p1[1][INS_W+ADDR_W +: ADDR_W],
                           dsp_ent_p1[0][INS_W+ADDR_W +: ADDR_W]};
    assign out_pred     = {dsp_ent_p1[1][ENT_W-1], dsp_ent_p1[0][ENT_W-1]};
    assign occupancy    = occ;
    assign full_to_if   = (occ >= WARN_LVL);

endmodule
